// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU (port 0) vs host/debug (port 1).
// Round-robin on ties, optional host burst lock, and a CPU starvation override of that lock.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_lock,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [7:0]    conflict_cnt
);

    localparam logic [0:0] ST_FREE        = 1'b0;
    localparam logic [0:0] ST_HOST_LOCKED = 1'b1;
    localparam logic       OWN_CPU        = 1'b0;
    localparam logic       OWN_HOST       = 1'b1;
    localparam logic [3:0] WAIT_MAX       = 4'(MAX_WAIT);

    logic [0:0]    state, state_d;
    logic          last_owner;
    logic [3:0]    wait_cnt;
    logic          override;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    // Grants are gated by reset so an asserted reset silences the memory at once.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        override = 1'b0;
        if (reset) begin
            if (state == ST_HOST_LOCKED && host_req) begin
                if (cpu_req && wait_cnt == WAIT_MAX) begin
                    cpu_gnt  = 1'b1;
                    override = 1'b1;
                end else begin
                    host_gnt = 1'b1;
                end
            end else if (cpu_req && host_req) begin
                if (last_owner == OWN_HOST) cpu_gnt  = 1'b1;
                else                        host_gnt = 1'b1;
            end else begin
                cpu_gnt  = cpu_req;
                host_gnt = host_req;
            end
        end
    end

    // The lock survives idle or host-absent cycles; only host_lock=0 or an override drops it.
    always_comb begin
        state_d = ST_FREE;
        if ((host_gnt && host_lock) ||
            (state == ST_HOST_LOCKED && host_lock && !override))
            state_d = ST_HOST_LOCKED;
    end

    assign m_we    = (cpu_gnt & cpu_we) | (host_gnt & host_we);
    assign m_addr  = cpu_gnt ? cpu_addr  : (host_gnt ? host_addr  : addr_q);
    assign m_wdata = cpu_gnt ? cpu_wdata : (host_gnt ? host_wdata : wdata_q);

    // Memory read data is only meaningful in the cycle after the read grant.
    assign cpu_rdata  = cpu_rvalid  ? m_rdata : '0;
    assign host_rdata = host_rvalid ? m_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_FREE;
            last_owner   <= OWN_HOST;
            wait_cnt     <= '0;
            conflict_cnt <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rvalid   <= 1'b0;
            host_rvalid  <= 1'b0;
        end else begin
            state   <= state_d;
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            if (cpu_gnt)       last_owner <= OWN_CPU;
            else if (host_gnt) last_owner <= OWN_HOST;
            if (!cpu_req || cpu_gnt)    wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
            if (cpu_req && host_req && conflict_cnt != 8'hFF)
                conflict_cnt <= conflict_cnt + 8'd1;
            cpu_rvalid  <= cpu_gnt & ~cpu_we;
            host_rvalid <= host_gnt & ~host_we;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic       clk, reset;
    logic       cpu_req, cpu_we, host_req, host_lock, host_we;
    logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic       cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, m_we;
    logic [7:0] cpu_rdata, host_rdata, m_addr, m_wdata, m_rdata, conflict_cnt;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_lock(host_lock), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .conflict_cnt(conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical memory: unwritten words read as addr ^ 8'h5A.
    logic [7:0] pmem [256];
    bit         pwr  [256];
    always @(posedge clk) begin
        m_rdata <= pwr[m_addr] ? pmem[m_addr] : (m_addr ^ 8'h5A);
        if (m_we) begin
            pmem[m_addr] <= m_wdata;
            pwr[m_addr]  <= 1'b1;
        end
    end

    // Reference model: winner code 0 = none, 1 = CPU, 2 = host.
    bit         md_locked, md_last_host, md_pc, md_ph;
    int         md_wait, md_conf, exp_w;
    logic [7:0] md_addr, md_wdata, md_pcd, md_phd, exp_addr, exp_wdata;
    logic       exp_we;
    logic [7:0] rmem [256];
    bit         rwr  [256];

    always_comb begin
        exp_w = 0;
        if (reset === 1'b1) begin
            if (md_locked && host_req)        exp_w = (cpu_req && md_wait >= MW) ? 1 : 2;
            else if (cpu_req && host_req)     exp_w = md_last_host ? 1 : 2;
            else if (cpu_req)                 exp_w = 1;
            else if (host_req)                exp_w = 2;
        end
        exp_we    = (exp_w == 1 && cpu_we) || (exp_w == 2 && host_we);
        exp_addr  = (exp_w == 1) ? cpu_addr  : (exp_w == 2) ? host_addr  : md_addr;
        exp_wdata = (exp_w == 1) ? cpu_wdata : (exp_w == 2) ? host_wdata : md_wdata;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_locked <= 1'b0; md_last_host <= 1'b1; md_wait <= 0; md_conf <= 0;
            md_addr <= '0; md_wdata <= '0; md_pc <= 1'b0; md_ph <= 1'b0;
        end else begin
            md_locked <= (exp_w == 2 && host_lock) ||
                         (md_locked && host_lock && !(exp_w == 1 && host_req));
            if (exp_w == 1) md_last_host <= 1'b0;
            else if (exp_w == 2) md_last_host <= 1'b1;
            md_wait <= (cpu_req && exp_w != 1) ? ((md_wait < MW) ? md_wait + 1 : md_wait) : 0;
            md_conf <= (cpu_req && host_req && md_conf < 255) ? md_conf + 1 : md_conf;
            md_addr  <= exp_addr;
            md_wdata <= exp_wdata;
            if (exp_we) begin
                rmem[exp_addr] <= exp_wdata;
                rwr[exp_addr]  <= 1'b1;
            end
            md_pc  <= (exp_w == 1) && !cpu_we;
            md_ph  <= (exp_w == 2) && !host_we;
            md_pcd <= rwr[cpu_addr]  ? rmem[cpu_addr]  : (cpu_addr  ^ 8'h5A);
            md_phd <= rwr[host_addr] ? rmem[host_addr] : (host_addr ^ 8'h5A);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_lock = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        cpu_req = 1; host_req = 1; cpu_we = 1;
        #3;
        total += 9;
        if (cpu_gnt !== 1'b0)      begin bad++; $display("FAIL reset_cpu_gnt: got %b want 0", cpu_gnt); end
        if (host_gnt !== 1'b0)     begin bad++; $display("FAIL reset_host_gnt: got %b want 0", host_gnt); end
        if (m_we !== 1'b0)         begin bad++; $display("FAIL reset_m_we: got %b want 0", m_we); end
        if (cpu_rvalid !== 1'b0)   begin bad++; $display("FAIL reset_cpu_rvalid: got %b want 0", cpu_rvalid); end
        if (host_rvalid !== 1'b0)  begin bad++; $display("FAIL reset_host_rvalid: got %b want 0", host_rvalid); end
        if (m_addr !== 8'h00)      begin bad++; $display("FAIL reset_m_addr: got %h want 00", m_addr); end
        if (m_wdata !== 8'h00)     begin bad++; $display("FAIL reset_m_wdata: got %h want 00", m_wdata); end
        if (conflict_cnt !== 8'h0) begin bad++; $display("FAIL reset_conflict: got %0d want 0", conflict_cnt); end
        if (cpu_rdata !== 8'h00)   begin bad++; $display("FAIL reset_cpu_rdata: got %h want 00", cpu_rdata); end
        repeat (2) @(posedge clk);
        idle_inputs();
        #1 reset = 1'b1;
    endtask

    task automatic test_preload();
        do_reset();
        host_req = 1; host_we = 1; host_addr = 8'd3; host_wdata = 8'hA5;
        @(negedge clk);
        total += 5;
        if (host_gnt !== 1'b1)  begin bad++; $display("FAIL preload_wr_gnt: got %b want 1", host_gnt); end
        if (cpu_gnt !== 1'b0)   begin bad++; $display("FAIL preload_wr_cpu_gnt: got %b want 0", cpu_gnt); end
        if (m_we !== 1'b1)      begin bad++; $display("FAIL preload_wr_we: got %b want 1", m_we); end
        if (m_addr !== 8'd3)    begin bad++; $display("FAIL preload_wr_addr: got %h want 03", m_addr); end
        if (m_wdata !== 8'hA5)  begin bad++; $display("FAIL preload_wr_data: got %h want a5", m_wdata); end
        next();
        host_we = 0;
        @(negedge clk);
        total += 3;
        if (host_gnt !== 1'b1)    begin bad++; $display("FAIL preload_rd_gnt: got %b want 1", host_gnt); end
        if (m_we !== 1'b0)        begin bad++; $display("FAIL preload_rd_we: got %b want 0", m_we); end
        if (host_rvalid !== 1'b0) begin bad++; $display("FAIL preload_wr_rvalid: got %b want 0", host_rvalid); end
        next();
        host_req = 0;
        total += 3;
        if (host_rvalid !== 1'b1) begin bad++; $display("FAIL preload_rvalid: got %b want 1", host_rvalid); end
        if (host_rdata !== 8'hA5) begin bad++; $display("FAIL preload_rdata: got %h want a5", host_rdata); end
        if (cpu_rvalid !== 1'b0)  begin bad++; $display("FAIL preload_cpu_rvalid: got %b want 0", cpu_rvalid); end
        next();
        total += 1;
        if (host_rvalid !== 1'b0) begin bad++; $display("FAIL preload_rvalid_drop: got %b want 0", host_rvalid); end
    endtask

    task automatic test_tie();
        do_reset();
        cpu_req = 1; cpu_addr = 8'd1; host_req = 1; host_addr = 8'd2;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) idle_inputs();
            @(negedge clk);
            if (i < 4) begin
                total += 2;
                if (cpu_gnt !== (i % 2 == 0))  begin bad++; $display("FAIL tie_cpu_gnt[%0d]: got %b want %b", i, cpu_gnt, i % 2 == 0); end
                if (host_gnt !== (i % 2 == 1)) begin bad++; $display("FAIL tie_host_gnt[%0d]: got %b want %b", i, host_gnt, i % 2 == 1); end
            end
            if (i > 0) begin
                total += 2;
                if (cpu_rvalid !== ((i - 1) % 2 == 0)) begin bad++; $display("FAIL tie_cpu_rvalid[%0d]: got %b", i, cpu_rvalid); end
                if (host_rvalid !== ((i - 1) % 2 == 1)) begin bad++; $display("FAIL tie_host_rvalid[%0d]: got %b", i, host_rvalid); end
                if ((i - 1) % 2 == 0) begin
                    total++;
                    if (cpu_rdata !== 8'h5B) begin bad++; $display("FAIL tie_cpu_rdata[%0d]: got %h want 5b", i, cpu_rdata); end
                end else begin
                    total++;
                    if (host_rdata !== 8'h58) begin bad++; $display("FAIL tie_host_rdata[%0d]: got %h want 58", i, host_rdata); end
                end
            end
            next();
        end
        total++;
        if (conflict_cnt !== 8'd4) begin bad++; $display("FAIL tie_conflict: got %0d want 4", conflict_cnt); end
    endtask

    task automatic test_starve();
        do_reset();
        host_req = 1; host_lock = 1; host_we = 1; host_addr = 8'd10; host_wdata = 8'h11;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1) begin bad++; $display("FAIL starve_first_host: got %b want 1", host_gnt); end
        next();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'd20;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total += 2;
            if (cpu_gnt !== (i == 5))  begin bad++; $display("FAIL starve_cpu_gnt[%0d]: got %b want %b", i, cpu_gnt, i == 5); end
            if (host_gnt !== (i != 5)) begin bad++; $display("FAIL starve_host_gnt[%0d]: got %b want %b", i, host_gnt, i != 5); end
            next();
        end
        total++;
        if (cpu_rvalid !== 1'b1) begin bad++; $display("FAIL starve_cpu_rvalid: got %b want 1", cpu_rvalid); end
        host_lock = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (host_gnt !== (i == 0)) begin bad++; $display("FAIL starve_after[%0d]: host_gnt got %b want %b", i, host_gnt, i == 0); end
            next();
        end
        idle_inputs();
    endtask

    task automatic test_lock_release();
        logic [3:0] exp_cpu;
        exp_cpu = 4'b1010;
        do_reset();
        host_req = 1; host_lock = 1; host_addr = 8'd5;
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1) begin bad++; $display("FAIL lockrel_setup: got %b want 1", host_gnt); end
        next();
        cpu_req = 1; cpu_addr = 8'd6; host_lock = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total += 2;
            if (cpu_gnt !== exp_cpu[i])   begin bad++; $display("FAIL lockrel_cpu[%0d]: got %b want %b", i, cpu_gnt, exp_cpu[i]); end
            if (host_gnt !== !exp_cpu[i]) begin bad++; $display("FAIL lockrel_host[%0d]: got %b want %b", i, host_gnt, !exp_cpu[i]); end
            next();
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        cpu_req = 1; host_req = 1;
        repeat (254) next();
        total++;
        if (conflict_cnt !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", conflict_cnt); end
        repeat (46) next();
        total++;
        if (conflict_cnt !== 8'd255) begin bad++; $display("FAIL sat_300: got %0d want 255", conflict_cnt); end
        repeat (5) next();
        total++;
        if (conflict_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", conflict_cnt); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        cpu_req = 1; cpu_addr = 8'd1; host_req = 1; host_addr = 8'd2;
        next();
        @(negedge clk);
        total++;
        if (host_gnt !== 1'b1) begin bad++; $display("FAIL arst_host_read: got %b want 1", host_gnt); end
        next();
        cpu_we = 1;
        total++;
        if (host_rvalid !== 1'b1) begin bad++; $display("FAIL arst_pending: got %b want 1", host_rvalid); end
        #2 reset = 1'b0;
        #1;
        total += 5;
        if (host_rvalid !== 1'b0)  begin bad++; $display("FAIL arst_host_rvalid: got %b want 0", host_rvalid); end
        if (cpu_gnt !== 1'b0)      begin bad++; $display("FAIL arst_cpu_gnt: got %b want 0", cpu_gnt); end
        if (host_gnt !== 1'b0)     begin bad++; $display("FAIL arst_host_gnt: got %b want 0", host_gnt); end
        if (m_we !== 1'b0)         begin bad++; $display("FAIL arst_m_we: got %b want 0", m_we); end
        if (conflict_cnt !== 8'd0) begin bad++; $display("FAIL arst_conflict: got %0d want 0", conflict_cnt); end
        @(negedge clk);
        #1 reset = 1'b1; cpu_we = 0;
        #1;
        total += 2;
        if (cpu_gnt !== 1'b1)  begin bad++; $display("FAIL arst_first_tie_cpu: got %b want 1", cpu_gnt); end
        if (host_gnt !== 1'b0) begin bad++; $display("FAIL arst_first_tie_host: got %b want 0", host_gnt); end
        next();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            cpu_req    = ($urandom_range(0, 9) < 7);
            cpu_we     = $urandom_range(0, 1);
            cpu_addr   = 8'($urandom_range(0, 15));
            cpu_wdata  = 8'($urandom);
            host_req   = ($urandom_range(0, 9) < 6);
            host_lock  = ($urandom_range(0, 9) < 6);
            host_we    = $urandom_range(0, 1);
            host_addr  = 8'($urandom_range(0, 15));
            host_wdata = 8'($urandom);
            @(negedge clk);
            total += 8;
            if (cpu_gnt !== (exp_w == 1))  begin bad++; $display("FAIL rnd_cpu_gnt@%0d: got %b want %b", n, cpu_gnt, exp_w == 1); end
            if (host_gnt !== (exp_w == 2)) begin bad++; $display("FAIL rnd_host_gnt@%0d: got %b want %b", n, host_gnt, exp_w == 2); end
            if (m_we !== exp_we)           begin bad++; $display("FAIL rnd_m_we@%0d: got %b want %b", n, m_we, exp_we); end
            if (m_addr !== exp_addr)       begin bad++; $display("FAIL rnd_m_addr@%0d: got %h want %h", n, m_addr, exp_addr); end
            if (m_wdata !== exp_wdata)     begin bad++; $display("FAIL rnd_m_wdata@%0d: got %h want %h", n, m_wdata, exp_wdata); end
            if (cpu_rvalid !== md_pc)      begin bad++; $display("FAIL rnd_cpu_rvalid@%0d: got %b want %b", n, cpu_rvalid, md_pc); end
            if (host_rvalid !== md_ph)     begin bad++; $display("FAIL rnd_host_rvalid@%0d: got %b want %b", n, host_rvalid, md_ph); end
            if (conflict_cnt !== 8'(md_conf)) begin bad++; $display("FAIL rnd_conflict@%0d: got %0d want %0d", n, conflict_cnt, md_conf); end
            if (md_pc) begin
                total++;
                if (cpu_rdata !== md_pcd) begin bad++; $display("FAIL rnd_cpu_rdata@%0d: got %h want %h", n, cpu_rdata, md_pcd); end
            end
            if (md_ph) begin
                total++;
                if (host_rdata !== md_phd) begin bad++; $display("FAIL rnd_host_rdata@%0d: got %h want %h", n, host_rdata, md_phd); end
            end
            next();
        end
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_tie();
        test_starve();
        test_lock_release();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
